pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline with I-cache and D-cache.
- Takes decode-stage register usage, execute-stage load/redirect status and cache busy flags.
- Drives the per-stage register enables and flushes: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Also tracks wrong-path fetches across I-cache misses, counts stall cycles and flags D-cache hangs.

Parameters:
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.
- MEM_TIMEOUT, 256: number of consecutive dmem_busy cycles that sets mem_timeout.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_opcode  input  7  instruction[6:0] of the instruction in decode.
- id_rs1  input  5  instruction[19:15] in decode.
- id_rs2  input  5  instruction[24:20] in decode.
- ex_rd  input  5  destination register of the instruction in execute.
- ex_d_mem_r  input  1  execute-stage instruction is a load.
- ex_write_reg_en  input  1  execute-stage instruction writes the register file.
- ex_branch_taken  input  1  resolved taken branch in execute.
- ex_jump  input  1  JAL/JALR in execute.
- imem_busy  input  1  I-cache miss in progress; fetch word is not valid.
- dmem_busy  input  1  D-cache miss in progress.
- stall_cnt_clr  input  1  synchronous clear of stall_count.
- pc_en  output  1  PC load enable.
- if_id_en  output  1  IF/ID load enable.
- if_id_flush  output  1  load NOP into IF/ID. Overrides if_id_en.
- id_ex_flush  output  1  load bubble into ID/EX.
- ex_mem_en  output  1  EX/MEM load enable.
- mem_wb_en  output  1  MEM/WB load enable.
- state  output  2  FSM state: RUN=0, MEM_WAIT=1, IFETCH_WAIT=2, DRAIN=3.
- stall_count  output  STALL_CNT_W  cycles with pc_en=0, saturating.
- mem_timeout  output  1  sticky D-cache hang flag.

Behaviour:
- Reset low, asynchronous:
  - Registers: state=RUN, stall_count=0, wait counter=0, mem_timeout=0.
  - Combinational outputs while reset is low: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_en=0, mem_wb_en=0.
- All enable/flush outputs are combinational from the registered state and current inputs (zero latency). State and counters update on the rising clk edge.
- rs1 usage: rs1 is used unless id_opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
- rs2 usage: rs2 is used only for opcodes 0110011 (R-type), 0100011 (store) and 1100011 (branch).
- Load-use hazard, lu = ex_d_mem_r & ex_write_reg_en & ex_rd!=0 & ((rs1 used & id_rs1==ex_rd) | (rs2 used & id_rs2==ex_rd)).
- redirect = ex_branch_taken | ex_jump.
- Priority, highest first:
  1. dmem_busy=1 (any state): all enables 0, all flushes 0 (full freeze). Next state is MEM_WAIT, except DRAIN stays DRAIN.
  2. state==DRAIN: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, ex/mem enables 1. Next state is RUN when imem_busy=0; otherwise stay DRAIN. The cycle in which imem_busy falls also discards the returned wrong-path word.
  3. redirect: pc_en=1, if_id_flush=1, id_ex_flush=1. Next state is DRAIN if imem_busy=1, otherwise RUN.
  4. lu: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=1. Next state is IFETCH_WAIT if imem_busy=1, otherwise RUN.
  5. imem_busy: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_flush=0. Next state is IFETCH_WAIT.
  6. Otherwise: pc_en=1, if_id_en=1, flushes 0. Next state is RUN.
- In rules 2-6, ex_mem_en=mem_wb_en=1.
- MEM_WAIT and IFETCH_WAIT use the same output rules as RUN; they are status only.
- A redirect held in EX during MEM_WAIT takes effect in the first cycle dmem_busy=0.
- Load-use inserts exactly one bubble, because the load leaves EX the next cycle.
- stall_count:
  - Increments when pc_en=0 and reset is high; saturates at all-ones.
  - stall_cnt_clr forces it to 0 and has priority over increment.
- Watchdog:
  - The wait counter counts consecutive dmem_busy=1 cycles and returns to 0 when dmem_busy=0.
  - On reaching MEM_TIMEOUT it sets mem_timeout=1 and stops counting.
  - mem_timeout is cleared only by reset.
- Reset asserted mid-miss or mid-DRAIN returns immediately to RUN with counters cleared.

Test Plan:
- Load-use: EX = lw x5 (ex_rd=5, ex_d_mem_r=1, ex_write_reg_en=1); ID = add x6,x5,x1 (opcode 0110011, rs1=5). Required: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1. Repeat with ex_rd=0, then with ID = lui: no stall in either case.
- Branch taken with imem_busy=0: required pc_en=1, if_id_flush=1, id_ex_flush=1 for one cycle; state stays RUN.
- Redirect during I-miss: ex_jump=1 with imem_busy=1 gives state=DRAIN next cycle. Hold imem_busy 3 more cycles, then drop it. Required: if_id_flush=1 in every DRAIN cycle including the drop cycle, then RUN with pc_en=1.
- D-miss freeze: dmem_busy=1 for 5 cycles while ex_branch_taken=1. Required: all enables 0, state=MEM_WAIT, stall_count=5. In the cycle dmem_busy drops, the redirect outputs appear.
- Watchdog: dmem_busy held 256 cycles sets mem_timeout=1 on cycle 256. It stays 1 after dmem_busy drops and clears only on reset=0.
- Async reset asserted mid-DRAIN with imem_busy=1: outputs take their reset values without a clock; after release, state=RUN and stall_count=0. Pulse stall_cnt_clr during a stall: count reads 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage RISC-V pipeline.
// It decides, every cycle, which pipeline registers load, which take a
// bubble/NOP, and tracks wrong-path fetches that are still in flight in the
// I-cache after a redirect.
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   id_opcode/rs1/rs2   decode-stage instruction fields
//   ex_rd, ex_d_mem_r,  execute-stage destination, load flag, write-enable,
//   ex_write_reg_en,    taken branch and jump
//   ex_branch_taken,
//   ex_jump
//   imem_busy/dmem_busy cache miss in progress
//   stall_cnt_clr       synchronous clear of stall_count
//   pc_en .. mem_wb_en  per-stage load enables and flushes (combinational)
//   state               FSM state (RUN/MEM_WAIT/IFETCH_WAIT/DRAIN)
//   stall_count         saturating count of cycles with pc_en=0
//   mem_timeout         sticky flag: D-cache busy for MEM_TIMEOUT cycles
module pipeline_hazard_controller #(
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             id_opcode,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_d_mem_r,
  input  logic                   ex_write_reg_en,
  input  logic                   ex_branch_taken,
  input  logic                   ex_jump,
  input  logic                   imem_busy,
  input  logic                   dmem_busy,
  input  logic                   stall_cnt_clr,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_timeout
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    IFETCH_WAIT = 2'd2,
    DRAIN       = 2'd3
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Wide enough to hold MEM_TIMEOUT itself, where the counter parks.
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rs1_used;
  logic              rs2_used;
  logic              load_use;
  logic              redirect;

  assign state = state_q;

  // Register-operand usage of the decode instruction, then the load-use test
  // against the load sitting in execute. x0 never creates a dependency.
  always_comb begin
    rs1_used = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) ||
                 (id_opcode == OP_JAL));
    rs2_used = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) ||
               (id_opcode == OP_BRANCH);
    load_use = ex_d_mem_r && ex_write_reg_en && (ex_rd != 5'd0) &&
               ((rs1_used && (id_rs1 == ex_rd)) ||
                (rs2_used && (id_rs2 == ex_rd)));
    redirect = ex_branch_taken || ex_jump;
  end

  // Output and next-state decode in priority order. A D-miss freezes the
  // whole pipe; DRAIN keeps discarding the wrong-path fetch until the I-cache
  // returns it (including the return cycle itself). MEM_WAIT and IFETCH_WAIT
  // decode exactly like RUN. When a redirect meets an I-miss, if_id_en is
  // left high because the flush overrides it anyway.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    state_d     = RUN;
    if (!reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      state_d     = RUN;
    end else if (dmem_busy) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      state_d     = (state_q == DRAIN) ? DRAIN : MEM_WAIT;
    end else if (state_q == DRAIN) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = imem_busy ? DRAIN : RUN;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = imem_busy ? DRAIN : RUN;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = imem_busy ? IFETCH_WAIT : RUN;
    end else if (imem_busy) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      state_d     = IFETCH_WAIT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating stall-cycle counter; the clear wins over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall_cnt_clr) begin
      stall_count <= '0;
    end else if (!pc_en && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  // D-cache watchdog: counts consecutive busy cycles, raises the sticky flag
  // on the MEM_TIMEOUT-th one and then parks the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (!dmem_busy) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt == WAIT_LAST) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Directed bench: a table of single-cycle vectors for the priority decode,
// followed by hand-written multi-cycle sequences (DRAIN, D-miss freeze,
// watchdog, asynchronous reset, stall counter clear).
module tb_pipeline_hazard_controller;

  localparam logic [6:0] R_T   = 7'b0110011;
  localparam logic [6:0] I_T   = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [5:0] O_NORM  = 6'b110011;
  localparam logic [5:0] O_LU    = 6'b000111;
  localparam logic [5:0] O_RED   = 6'b111111;
  localparam logic [5:0] O_IMISS = 6'b011011;
  localparam logic [5:0] O_FRZ   = 6'b000000;
  localparam logic [5:0] O_DRAIN = 6'b001111;
  localparam logic [5:0] O_RST   = 6'b001100;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_IW  = 2'd2;
  localparam logic [1:0] S_DR  = 2'd3;

  logic        clk;
  logic        reset;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rd;
  logic        ex_d_mem_r;
  logic        ex_write_reg_en;
  logic        ex_branch_taken;
  logic        ex_jump;
  logic        imem_busy;
  logic        dmem_busy;
  logic        stall_cnt_clr;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic        mem_timeout;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ld;
    logic       wr;
    logic       br;
    logic       jmp;
    logic       ib;
    logic       db;
    logic [5:0] exp_out;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  pipeline_hazard_controller #(
    .STALL_CNT_W(16),
    .MEM_TIMEOUT(256)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_opcode(id_opcode),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .ex_rd(ex_rd),
    .ex_d_mem_r(ex_d_mem_r),
    .ex_write_reg_en(ex_write_reg_en),
    .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump),
    .imem_busy(imem_busy),
    .dmem_busy(dmem_busy),
    .stall_cnt_clr(stall_cnt_clr),
    .pc_en(pc_en),
    .if_id_en(if_id_en),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en),
    .state(state),
    .stall_count(stall_count),
    .mem_timeout(mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outVec();
    return {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en};
  endfunction

  // Drives decode/execute/cache inputs and lets the combinational outputs settle.
  task automatic applyStimulus(input logic [6:0] opc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic ld, input logic wr, input logic br,
                               input logic jmp, input logic ib, input logic db);
    id_opcode       = opc;
    id_rs1          = rs1;
    id_rs2          = rs2;
    ex_rd           = rd;
    ex_d_mem_r      = ld;
    ex_write_reg_en = wr;
    ex_branch_taken = br;
    ex_jump         = jmp;
    imem_busy       = ib;
    dmem_busy       = db;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string name, input logic [6:0] opc,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ld, input logic wr,
                        input logic br, input logic jmp, input logic ib,
                        input logic db, input logic [5:0] eo,
                        input logic [1:0] es);
    vec_t v;
    v.name = name; v.opc = opc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.ld = ld; v.wr = wr; v.br = br; v.jmp = jmp; v.ib = ib; v.db = db;
    v.exp_out = eo; v.exp_state = es;
    vecs.push_back(v);
  endtask

  initial begin
    stall_cnt_clr = 1'b0;
    reset = 1'b0;
    applyStimulus(R_T, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0);
    #1;
    checkOutput("reset_outputs", 32'(outVec()), 32'(O_RST));
    checkOutput("reset_state", 32'(state), 32'(S_RUN));
    checkOutput("reset_count", 32'(stall_count), 32'd0);
    checkOutput("reset_timeout", 32'(mem_timeout), 32'd0);
    #3;
    reset = 1'b1;
    tick();

    addVec("lu_rs1",        R_T,   5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0, O_LU,    S_RUN);
    addVec("lu_rd0",        R_T,   5'd0, 5'd1, 5'd0, 1, 1, 0, 0, 0, 0, O_NORM,  S_RUN);
    addVec("lui_no_rs1",    LUI,   5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, O_NORM,  S_RUN);
    addVec("auipc_no_rs1",  AUIPC, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, O_NORM,  S_RUN);
    addVec("jal_no_rs1",    JAL,   5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, O_NORM,  S_RUN);
    addVec("jalr_rs1",      JALR,  5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0, O_LU,    S_RUN);
    addVec("lu_rs2",        R_T,   5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, O_LU,    S_RUN);
    addVec("itype_no_rs2",  I_T,   5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, O_NORM,  S_RUN);
    addVec("store_rs2",     STORE, 5'd1, 5'd7, 5'd7, 1, 1, 0, 0, 0, 0, O_LU,    S_RUN);
    addVec("branch_rs2",    BR,    5'd2, 5'd9, 5'd9, 1, 1, 0, 0, 0, 0, O_LU,    S_RUN);
    addVec("load_no_wr",    R_T,   5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 0, 0, O_NORM,  S_RUN);
    addVec("alu_not_load",  R_T,   5'd5, 5'd1, 5'd5, 0, 1, 0, 0, 0, 0, O_NORM,  S_RUN);
    addVec("br_taken",      R_T,   5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, O_RED,   S_RUN);
    addVec("redir_over_lu", R_T,   5'd5, 5'd1, 5'd5, 1, 1, 0, 1, 0, 0, O_RED,   S_RUN);
    addVec("imiss",         I_T,   5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0, O_IMISS, S_IW);
    addVec("lu_in_imiss",   R_T,   5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 1, 0, O_LU,    S_IW);
    addVec("dmiss_freeze",  R_T,   5'd5, 5'd1, 5'd5, 1, 1, 1, 0, 1, 1, O_FRZ,   S_MW);
    addVec("resume",        I_T,   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, O_NORM,  S_RUN);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].opc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                    vecs[i].ld, vecs[i].wr, vecs[i].br, vecs[i].jmp,
                    vecs[i].ib, vecs[i].db);
      checkOutput({vecs[i].name, "_out"}, 32'(outVec()), 32'(vecs[i].exp_out));
      tick();
      checkOutput({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].exp_state));
    end

    // Load-use counts exactly one stall cycle.
    stall_cnt_clr = 1'b1;
    applyStimulus(I_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    tick();
    stall_cnt_clr = 1'b0;
    applyStimulus(R_T, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0);
    tick();
    applyStimulus(R_T, 5'd5, 5'd1, 5'd6, 0, 1, 0, 0, 0, 0);
    checkOutput("lu_after_out", 32'(outVec()), 32'(O_NORM));
    checkOutput("lu_count", 32'(stall_count), 32'd1);

    // Redirect during an I-miss, then DRAIN for three more cycles.
    applyStimulus(R_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0);
    checkOutput("jmp_imiss_out", 32'(outVec()), 32'(O_RED));
    tick();
    checkOutput("enter_drain", 32'(state), 32'(S_DR));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(R_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
      checkOutput("drain_out", 32'(outVec()), 32'(O_DRAIN));
      tick();
      checkOutput("drain_state", 32'(state), 32'(S_DR));
    end
    applyStimulus(R_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain_drop_out", 32'(outVec()), 32'(O_DRAIN));
    tick();
    checkOutput("drain_exit_state", 32'(state), 32'(S_RUN));
    checkOutput("drain_exit_out", 32'(outVec()), 32'(O_NORM));

    // D-miss freeze with a taken branch waiting in EX.
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(R_T, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1);
      checkOutput("freeze_out", 32'(outVec()), 32'(O_FRZ));
      tick();
    end
    checkOutput("freeze_state", 32'(state), 32'(S_MW));
    checkOutput("freeze_count", 32'(stall_count), 32'd5);
    applyStimulus(R_T, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    checkOutput("freeze_release_out", 32'(outVec()), 32'(O_RED));
    tick();
    checkOutput("freeze_release_state", 32'(state), 32'(S_RUN));

    // Watchdog boundary: still clear after 255 busy cycles, set on the 256th.
    applyStimulus(I_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 255; i++) tick();
    checkOutput("wd_255", 32'(mem_timeout), 32'd0);
    tick();
    checkOutput("wd_256", 32'(mem_timeout), 32'd1);
    applyStimulus(I_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("wd_sticky", 32'(mem_timeout), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("wd_reset_clear", 32'(mem_timeout), 32'd0);
    reset = 1'b1;
    tick();

    // Asynchronous reset in the middle of DRAIN.
    applyStimulus(R_T, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0);
    tick();
    applyStimulus(R_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
    checkOutput("pre_reset_drain", 32'(state), 32'(S_DR));
    reset = 1'b0;
    #1;
    checkOutput("async_rst_out", 32'(outVec()), 32'(O_RST));
    checkOutput("async_rst_state", 32'(state), 32'(S_RUN));
    checkOutput("async_rst_count", 32'(stall_count), 32'd0);
    #1;
    reset = 1'b1;
    applyStimulus(I_T, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("post_rst_state", 32'(state), 32'(S_RUN));
    checkOutput("post_rst_count", 32'(stall_count), 32'd0);

    // Clear wins over increment while stalling.
    applyStimulus(R_T, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0);
    tick();
    checkOutput("clr_pre_count", 32'(stall_count), 32'd1);
    stall_cnt_clr = 1'b1;
    applyStimulus(R_T, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0);
    tick();
    stall_cnt_clr = 1'b0;
    checkOutput("clr_in_stall", 32'(stall_count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
